// File: rtl/fp32_mul_arbiter.sv
// fp32_mul_arbiter: round-robin arbiter that shares one external FP32 multiplier
// among NUM_REQ requesters, one transaction at a time, with a done timeout.
module fp32_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic                          mul_valid_o,
    output logic [DATA_WIDTH-1:0]         mul_a_o,
    output logic [DATA_WIDTH-1:0]         mul_b_o,
    input  logic [DATA_WIDTH-1:0]         mul_result_i,
    input  logic                          mul_done_i
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DATA_WIDTH-1:0] QNAN     = DATA_WIDTH'(32'h7FC0_0000);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  last_grant_q;
    logic [IDX_W-1:0]  grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              timeout_hit;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = (int'(base) + offset) % NUM_REQ;
        return sum[IDX_W-1:0];
    endfunction

    // Search starts just after the last served requester so everyone gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req_valid_i[rr_idx(last_grant_q, i + 1)]) begin
                pick_found = 1'b1;
                pick_idx   = rr_idx(last_grant_q, i + 1);
            end
        end
    end

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready is gated by reset so nothing is accepted while reset is held.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        mul_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && !rst_i) begin
                    req_ready_o = NUM_REQ'(1) << pick_idx;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                mul_valid_o = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (mul_done_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = NUM_REQ'(1) << grant_q;
                if (rsp_ready_i[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Done is tested before the timeout so a completion on the last cycle still wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= IDX_LAST;
            grant_q      <= '0;
            cnt_q        <= '0;
            mul_a_o      <= '0;
            mul_b_o      <= '0;
            rsp_data_o   <= '0;
            rsp_err_o    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        mul_a_o <= req_a_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        mul_b_o <= req_b_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                end
                WAIT: begin
                    if (mul_done_i) begin
                        rsp_data_o <= mul_result_i;
                        rsp_err_o  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data_o <= QNAN;
                        rsp_err_o  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i[grant_q]) begin
                        last_grant_q <= grant_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
